// File: rtl/sprite_fetch.sv
// Sprite pixel fetch: maps beam position to frame-RAM address, realigns the
// RAM's registered read with the hit test and steps the animation frame in vblank.
module sprite_fetch #(
    parameter int unsigned SPR_W       = 16,
    parameter int unsigned SPR_H       = 16,
    parameter int unsigned NUM_FRAMES  = 4,
    parameter int unsigned SHEET_BASE  = 0,
    parameter int unsigned ANIM_DIV    = 8,
    parameter logic [7:0]  TRANSPARENT = 8'h00,
    parameter int unsigned ADDR_W      = 20,
    localparam int unsigned AF_W       = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              pix_valid,
    input  logic              frame_start,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip_h,
    input  logic              anim_en,
    input  logic [7:0]        ram_data,
    output logic [ADDR_W-1:0] read_address,
    output logic [7:0]        pix_index,
    output logic              pix_opaque,
    output logic              pix_out_valid,
    output logic [AF_W-1:0]   anim_frame
);

    localparam int unsigned DIV_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    logic [ADDR_W-1:0] read_address_q, read_address_d;
    logic              hit_d1_q, hit_d1_d, valid_d1_q, valid_d1_d;
    logic              hit_d2_q, hit_d2_d, valid_d2_q, valid_d2_d;
    logic [7:0]        pix_index_q, pix_index_d;
    logic              pix_opaque_q, pix_opaque_d;
    logic              pix_out_valid_q, pix_out_valid_d;
    logic [AF_W-1:0]   anim_frame_q, anim_frame_d;
    logic [DIV_W-1:0]  div_q, div_d;

    logic [10:0]       dx_c, dy_c, col_c, x_end_c, y_end_c;
    logic              hit_c;
    logic [ADDR_W-1:0] addr_c;

    // Stage 0: 11-bit bounds so a sprite near the right/bottom edge never wraps.
    always_comb begin
        dx_c    = {1'b0, DrawX} - {1'b0, sprite_x};
        dy_c    = {1'b0, DrawY} - {1'b0, sprite_y};
        x_end_c = {1'b0, sprite_x} + 11'(SPR_W);
        y_end_c = {1'b0, sprite_y} + 11'(SPR_H);
        hit_c   = pix_valid
                  && (DrawX >= sprite_x) && ({1'b0, DrawX} < x_end_c)
                  && (DrawY >= sprite_y) && ({1'b0, DrawY} < y_end_c);
        col_c   = flip_h ? (11'(SPR_W - 1) - dx_c) : dx_c;
        addr_c  = ADDR_W'(SHEET_BASE)
                  + ADDR_W'(anim_frame_q) * ADDR_W'(SPR_W * SPR_H)
                  + ADDR_W'(dy_c) * ADDR_W'(SPR_W)
                  + ADDR_W'(col_c);
    end

    // Pipeline next-state and animation divider.
    always_comb begin
        read_address_d  = hit_c ? addr_c : ADDR_W'(SHEET_BASE);
        hit_d1_d        = hit_c;
        valid_d1_d      = pix_valid;
        hit_d2_d        = hit_d1_q;
        valid_d2_d      = valid_d1_q;
        pix_opaque_d    = hit_d2_q && (ram_data != TRANSPARENT);
        pix_index_d     = pix_opaque_d ? ram_data : 8'h00;
        pix_out_valid_d = valid_d2_q;
        div_d           = div_q;
        anim_frame_d    = anim_frame_q;
        if (frame_start) begin
            if (!anim_en) begin
                div_d = '0;
            end else if (div_q == DIV_W'(ANIM_DIV - 1)) begin
                div_d        = '0;
                anim_frame_d = (anim_frame_q == AF_W'(NUM_FRAMES - 1))
                               ? '0 : anim_frame_q + AF_W'(1);
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            read_address_q  <= ADDR_W'(SHEET_BASE);
            hit_d1_q        <= 1'b0;
            valid_d1_q      <= 1'b0;
            hit_d2_q        <= 1'b0;
            valid_d2_q      <= 1'b0;
            pix_index_q     <= 8'h00;
            pix_opaque_q    <= 1'b0;
            pix_out_valid_q <= 1'b0;
            anim_frame_q    <= '0;
            div_q           <= '0;
        end else begin
            read_address_q  <= read_address_d;
            hit_d1_q        <= hit_d1_d;
            valid_d1_q      <= valid_d1_d;
            hit_d2_q        <= hit_d2_d;
            valid_d2_q      <= valid_d2_d;
            pix_index_q     <= pix_index_d;
            pix_opaque_q    <= pix_opaque_d;
            pix_out_valid_q <= pix_out_valid_d;
            anim_frame_q    <= anim_frame_d;
            div_q           <= div_d;
        end
    end

    assign read_address  = read_address_q;
    assign pix_index     = pix_index_q;
    assign pix_opaque    = pix_opaque_q;
    assign pix_out_valid = pix_out_valid_q;
    assign anim_frame    = anim_frame_q;

endmodule

// File: doc/sprite_fetch.md
Name: sprite_fetch

Overview:
- Downstream consumer of the sprite frame RAM.
- Maps the VGA beam position (DrawX/DrawY) plus a sprite's screen position to a RAM read address.
- Compensates for the RAM's 1-cycle registered read and emits a per-pixel 8-bit palette index with a transparency/opaque flag for the colour mapper.
- Steps the sprite animation frame in vertical blanking.

Parameters:
- SPR_W, 16, sprite width in pixels (power of 2 not required)
- SPR_H, 16, sprite height in pixels
- NUM_FRAMES, 4, animation frames stored consecutively in RAM
- SHEET_BASE, 0, RAM address of frame 0, pixel (0,0)
- ANIM_DIV, 8, video frames per animation step (>=1)
- TRANSPARENT, 8'h00, palette index treated as see-through
- ADDR_W, 20, RAM address width

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- pix_valid  in  1  beam in active video this cycle
- frame_start  in  1  one-cycle pulse at start of vertical blanking
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- flip_h  in  1  mirror sprite horizontally
- anim_en  in  1  enable animation stepping
- ram_data  in  8  frame RAM data_Out
- read_address  out  ADDR_W  to frame RAM read_address
- pix_index  out  8  palette index of sprite pixel, 0 when not opaque
- pix_opaque  out  1  sprite covers this pixel with a non-transparent colour
- pix_out_valid  out  1  pix_valid delayed to align with pix_index
- anim_frame  out  clog2(NUM_FRAMES)  current animation frame

Behaviour:
- Reset (async, Reset_n=0): read_address=SHEET_BASE, pix_index=0, pix_opaque=0, pix_out_valid=0, anim_frame=0, divider=0, all pipeline valid/hit bits cleared.
  - Reset asserted mid-line drops in-flight pixels; no output valid until 3 cycles after first pix_valid following release.
- Hit test, stage 0, combinational on inputs:
  - dx = DrawX - sprite_x; dy = DrawY - sprite_y, both computed 11-bit.
  - hit = pix_valid and DrawX>=sprite_x and DrawX<sprite_x+SPR_W and DrawY>=sprite_y and DrawY<sprite_y+SPR_H.
  - Sums are 11-bit, so a sprite near column 1023 never wraps to column 0.
- Address:
  - col = flip_h ? SPR_W-1-dx : dx.
  - addr = SHEET_BASE + anim_frame*SPR_W*SPR_H + dy*SPR_W + col, truncated to ADDR_W.
  - Registered into read_address at edge N+1 if hit; else read_address <= SHEET_BASE.
- Pipeline (input at cycle N):
  - N+1: read_address, hit_d1, valid_d1 registered.
  - N+2: RAM presents ram_data; hit_d2, valid_d2 registered.
  - N+3: outputs registered:
    - pix_opaque = hit_d2 && ram_data!=TRANSPARENT
    - pix_index = pix_opaque ? ram_data : 0
    - pix_out_valid = valid_d2
  - Latency fixed at 3 cycles, fully pipelined, one pixel per cycle, no stalls.
- Animation, evaluated on frame_start only:
  - anim_en=0: divider cleared, anim_frame holds.
  - anim_en=1: divider increments. At divider==ANIM_DIV-1, divider<=0 and anim_frame<=(anim_frame==NUM_FRAMES-1)?0:anim_frame+1.
  - ANIM_DIV=1 steps every frame.
- Simultaneous frame_start and pix_valid: that pixel uses the old anim_frame; the new value applies from the next cycle.
- sprite_x/sprite_y/flip_h are sampled every cycle. The caller changes them only in blanking; mid-line changes take effect on the next pixel with no glitch protection.

Test Plan:
- SPR 16x16, sprite (100,50), anim_frame 0. Beam (100,50) -> read_address=0 at N+1. Beam (115,65) -> read_address=255. Beam (116,50) -> no hit, pix_opaque=0 at N+3.
- flip_h=1, beam (100,50) -> read_address=15. Beam (115,50) -> 0.
- ram_data=8'h00 at N+2 -> pix_opaque=0, pix_index=0 at N+3. ram_data=8'h2A -> pix_opaque=1, pix_index=8'h2A, pix_out_valid=1.
- anim_en=1, ANIM_DIV=8: 8 frame_start pulses -> anim_frame=1, beam (100,50) addr=256. 32 pulses -> anim_frame=0. anim_en=0 for 5 pulses -> anim_frame unchanged.
- Edge: sprite_x=1020, beam DrawX=3 -> no hit. sprite_x=1020, DrawX=1023 -> hit, col 3.
- Reset_n pulsed low during a streaming line -> all outputs 0 immediately. After release, first pix_out_valid appears exactly 3 cycles after first pix_valid.
